// File: rtl/imem_responder.sv
// Instruction-fetch responder: synchronous-read program memory behind a fixed-latency,
// cancellable response pipeline, with a free-running program-load write port.
module imem_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 1,
  parameter logic [31:0] NOP        = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  req,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic                  cancel,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [31:0]           ld_data,
  output logic [31:0]           instr,
  output logic                  instr_valid,
  output logic [DEPTH_LOG2-1:0] resp_addr,
  output logic [15:0]           served_cnt
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]                            mem_q [DEPTH];
  logic [31:0]                            rd_word;

  logic [LATENCY-1:0][31:0]               data_q, data_d;
  logic [LATENCY-1:0][DEPTH_LOG2-1:0]     tag_q, tag_d;
  logic [LATENCY-1:0]                     vld_q, vld_d;
  logic [DEPTH_LOG2-1:0]                  last_tag_q, last_tag_d;
  logic [15:0]                            cnt_q, cnt_d;

  logic                                   accept;
  logic                                   out_vld;

  assign accept  = req & ~cancel;
  assign out_vld = vld_q[LATENCY-1];

  // The read samples the array before this edge's load lands, which gives
  // read-before-write on a same-address collision.
  assign rd_word = mem_q[addr];

  always_ff @(posedge clk) begin
    if (rst_ && ld_en) begin
      mem_q[ld_addr] <= ld_data;
    end
  end

  always_comb begin
    data_d     = data_q << 32;
    tag_d      = tag_q << DEPTH_LOG2;
    vld_d      = vld_q << 1;
    last_tag_d = last_tag_q;
    cnt_d      = cnt_q;

    if (accept) begin
      data_d[0] = rd_word;
      tag_d[0]  = addr;
      vld_d[0]  = 1'b1;
    end

    if (cancel) begin
      vld_d = '0;
    end

    if (out_vld) begin
      last_tag_d = tag_q[LATENCY-1];
      cnt_d      = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      vld_q      <= '0;
      last_tag_q <= '0;
      cnt_q      <= '0;
    end else begin
      vld_q      <= vld_d;
      last_tag_q <= last_tag_d;
      cnt_q      <= cnt_d;
    end
  end

  // Payload is only meaningful alongside its valid bit, so it needs no reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    tag_q  <= tag_d;
  end

  assign instr_valid = out_vld;
  assign instr       = out_vld ? data_q[LATENCY-1] : NOP;
  assign resp_addr   = out_vld ? tag_q[LATENCY-1] : last_tag_q;
  assign served_cnt  = cnt_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three instances (LATENCY 1,2,3) share one stimulus stream and
// are checked against a time-scheduled response model plus directed constant expectations.
module tb_imem_responder;

  localparam int          DL  = 6;
  localparam int          NI  = 3;
  localparam logic [31:0] NOP = 32'h00000013;

  logic          clk = 1'b0;
  logic          rst_;
  logic          req;
  logic [DL-1:0] addr;
  logic          cancel;
  logic          ld_en;
  logic [DL-1:0] ld_addr;
  logic [31:0]   ld_data;

  logic [31:0]   instr_o [NI];
  logic          valid_o [NI];
  logic [DL-1:0] raddr_o [NI];
  logic [15:0]   cnt_o   [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    imem_responder #(.DEPTH_LOG2(DL), .LATENCY(g + 1), .NOP(NOP)) u_dut (
      .clk        (clk),
      .rst_       (rst_),
      .req        (req),
      .addr       (addr),
      .cancel     (cancel),
      .ld_en      (ld_en),
      .ld_addr    (ld_addr),
      .ld_data    (ld_data),
      .instr      (instr_o[g]),
      .instr_valid(valid_o[g]),
      .resp_addr  (raddr_o[g]),
      .served_cnt (cnt_o[g])
    );
  end

  // Reference model: responses are scheduled by the absolute edge after which they show.
  logic [31:0]   ref_mem [2**DL];
  logic          sv [NI][8];
  logic [31:0]   sd [NI][8];
  logic [DL-1:0] sa [NI][8];
  logic [15:0]   ref_cnt  [NI];
  logic [DL-1:0] ref_last [NI];
  int            edge_n = 0;
  int            checks = 0;
  int            failures = 0;

  task automatic step();
    @(posedge clk);
    edge_n++;
    for (int k = 0; k < NI; k++) begin
      int p, n, d;
      p = (edge_n - 1) % 8;
      n = edge_n % 8;
      if (!rst_) begin
        for (int s = 0; s < 8; s++) sv[k][s] = 1'b0;
        ref_cnt[k]  = '0;
        ref_last[k] = '0;
      end else begin
        if (sv[k][p]) begin
          ref_cnt[k] = ref_cnt[k] + 16'd1;
          sv[k][p]   = 1'b0;
        end
        if (cancel) begin
          for (int s = 0; s < 8; s++) sv[k][s] = 1'b0;
        end else if (req) begin
          d        = (edge_n + k) % 8;
          sv[k][d] = 1'b1;
          sd[k][d] = ref_mem[addr];
          sa[k][d] = addr;
        end
      end
      if (sv[k][n]) ref_last[k] = sa[k][n];
    end
    if (rst_ && ld_en) ref_mem[ld_addr] = ld_data;
    #1;
  endtask

  function automatic logic exp_v(int k);
    return sv[k][edge_n % 8];
  endfunction

  function automatic logic [31:0] exp_i(int k);
    return sv[k][edge_n % 8] ? sd[k][edge_n % 8] : NOP;
  endfunction

  task automatic idle_inputs();
    req = 1'b0; cancel = 1'b0; ld_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_ = 1'b0; req = 1'b1; addr = 3; cancel = 1'b0; ld_en = 1'b0;
    ld_addr = 0; ld_data = 0;
    step();
    step();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (valid_o[k] !== 1'b0) begin failures++; $display("FAIL reset_valid inst%0d: got %b want 0", k, valid_o[k]); end
      checks++;
      if (instr_o[k] !== 32'h00000013) begin failures++; $display("FAIL reset_instr inst%0d: got %h want 00000013", k, instr_o[k]); end
      checks++;
      if (cnt_o[k] !== 16'h0000) begin failures++; $display("FAIL reset_cnt inst%0d: got %h want 0000", k, cnt_o[k]); end
      checks++;
      if (raddr_o[k] !== '0) begin failures++; $display("FAIL reset_raddr inst%0d: got %h want 0", k, raddr_o[k]); end
    end
  endtask

  task automatic load_mem();
    rst_ = 1'b1; idle_inputs();
    for (int a = 0; a < 2**DL; a++) begin
      ld_en = 1'b1; ld_addr = DL'(a); ld_data = $urandom;
      step();
    end
    ld_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [4];
    int j;
    w[0] = 32'h00500093; w[1] = 32'h00100113; w[2] = 32'h002081B3; w[3] = 32'h00000013;
    for (int a = 0; a < 4; a++) begin
      ld_en = 1'b1; ld_addr = DL'(a); ld_data = w[a];
      step();
    end
    ld_en = 1'b0;
    for (int c = 0; c < 8; c++) begin
      req = (c < 4); addr = DL'(c % 4);
      step();
      for (int k = 0; k < NI; k++) begin
        j = c - k;
        if (j >= 0 && j < 4) begin
          checks++;
          if (valid_o[k] !== 1'b1 || instr_o[k] !== w[j]) begin
            failures++; $display("FAIL b2b_data inst%0d c%0d: got v=%b %h want v=1 %h", k, c, valid_o[k], instr_o[k], w[j]);
          end
          checks++;
          if (raddr_o[k] !== DL'(j)) begin failures++; $display("FAIL b2b_raddr inst%0d c%0d: got %0d want %0d", k, c, raddr_o[k], j); end
        end else begin
          checks++;
          if (valid_o[k] !== 1'b0 || instr_o[k] !== NOP) begin
            failures++; $display("FAIL b2b_idle inst%0d c%0d: got v=%b %h want v=0 %h", k, c, valid_o[k], instr_o[k], NOP);
          end
          checks++;
          if (raddr_o[k] !== DL'((j < 0) ? 0 : 3)) begin failures++; $display("FAIL b2b_hold inst%0d c%0d: got %0d", k, c, raddr_o[k]); end
        end
      end
    end
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (cnt_o[k] !== 16'd4) begin failures++; $display("FAIL b2b_cnt inst%0d: got %0d want 4", k, cnt_o[k]); end
    end
  endtask

  task automatic test_cancel();
    logic [15:0] want_cnt [NI];
    want_cnt[0] = 16'd7; want_cnt[1] = 16'd6; want_cnt[2] = 16'd5;
    for (int a = 5; a <= 8; a++) begin
      ld_en = 1'b1; ld_addr = DL'(a); ld_data = 32'hC0DE0000 | a;
      step();
    end
    ld_en = 1'b0;
    for (int c = 0; c < 8; c++) begin
      req = (c < 4); addr = DL'(5 + c); cancel = (c == 2);
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (valid_o[k] !== exp_v(k) || instr_o[k] !== exp_i(k) || raddr_o[k] !== ref_last[k]) begin
          failures++; $display("FAIL cancel_model inst%0d c%0d: got v=%b %h a=%0d want v=%b %h a=%0d",
                               k, c, valid_o[k], instr_o[k], raddr_o[k], exp_v(k), exp_i(k), ref_last[k]);
        end
      end
      checks++;
      if (c == 5) begin
        if (valid_o[2] !== 1'b1 || instr_o[2] !== 32'hC0DE0008 || raddr_o[2] !== DL'(8)) begin
          failures++; $display("FAIL cancel_l3_resp c%0d: got v=%b %h a=%0d want v=1 c0de0008 a=8", c, valid_o[2], instr_o[2], raddr_o[2]);
        end
      end else begin
        if (valid_o[2] !== 1'b0 || instr_o[2] !== NOP || raddr_o[2] !== DL'((c < 5) ? 3 : 8)) begin
          failures++; $display("FAIL cancel_l3_idle c%0d: got v=%b %h a=%0d", c, valid_o[2], instr_o[2], raddr_o[2]);
        end
      end
    end
    cancel = 1'b0;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (cnt_o[k] !== want_cnt[k]) begin failures++; $display("FAIL cancel_cnt inst%0d: got %0d want %0d", k, cnt_o[k], want_cnt[k]); end
    end
  endtask

  task automatic test_collision();
    logic [31:0] w [2];
    int j;
    w[0] = 32'hAAAA0000; w[1] = 32'h12345678;
    ld_en = 1'b1; ld_addr = 9; ld_data = 32'hAAAA0000;
    step();
    for (int c = 0; c < 6; c++) begin
      req = (c < 2); addr = 9;
      ld_en = (c == 0); ld_addr = 9; ld_data = 32'h12345678;
      step();
      for (int k = 0; k < NI; k++) begin
        j = c - k;
        checks++;
        if (j == 0 || j == 1) begin
          if (valid_o[k] !== 1'b1 || instr_o[k] !== w[j] || raddr_o[k] !== DL'(9)) begin
            failures++; $display("FAIL collision inst%0d c%0d: got v=%b %h a=%0d want v=1 %h a=9", k, c, valid_o[k], instr_o[k], raddr_o[k], w[j]);
          end
        end else if (valid_o[k] !== 1'b0) begin
          failures++; $display("FAIL collision_idle inst%0d c%0d: got v=%b want 0", k, c, valid_o[k]);
        end
      end
    end
    ld_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    ld_en = 1'b1; ld_addr = 12; ld_data = 32'h00001212;
    step();
    for (int c = 0; c < 6; c++) begin
      rst_ = (c != 1); req = (c < 2); addr = DL'(10 + c);
      ld_en = (c == 1); ld_addr = 12; ld_data = 32'hDEADBEEF;
      step();
      for (int k = 0; k < NI; k++) begin
        if (c >= 1 || k >= 1) begin
          checks++;
          if (valid_o[k] !== 1'b0 || instr_o[k] !== NOP) begin
            failures++; $display("FAIL rstmid_resp inst%0d c%0d: got v=%b %h want v=0 %h", k, c, valid_o[k], instr_o[k], NOP);
          end
        end
        if (c >= 1) begin
          checks++;
          if (cnt_o[k] !== 16'd0) begin failures++; $display("FAIL rstmid_cnt inst%0d c%0d: got %0d want 0", k, c, cnt_o[k]); end
        end
      end
    end
    rst_ = 1'b1; ld_en = 1'b0; req = 1'b1; addr = 12;
    step();
    checks++;
    if (valid_o[0] !== 1'b1 || instr_o[0] !== 32'h00001212) begin
      failures++; $display("FAIL rstmid_noload: got v=%b %h want v=1 00001212", valid_o[0], instr_o[0]);
    end
    req = 1'b0;
    for (int c = 0; c < 4; c++) step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rst_    = ($urandom_range(0, 99) != 0);
      req     = ($urandom_range(0, 3) != 0);
      addr    = DL'($urandom);
      cancel  = ($urandom_range(0, 9) == 0);
      ld_en   = ($urandom_range(0, 3) == 0);
      ld_addr = ($urandom_range(0, 1) != 0) ? addr : DL'($urandom);
      ld_data = $urandom;
      step();
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (valid_o[k] !== exp_v(k)) begin failures++; $display("FAIL rnd_valid inst%0d c%0d: got %b want %b", k, c, valid_o[k], exp_v(k)); end
        checks++;
        if (instr_o[k] !== exp_i(k)) begin failures++; $display("FAIL rnd_instr inst%0d c%0d: got %h want %h", k, c, instr_o[k], exp_i(k)); end
        checks++;
        if (raddr_o[k] !== ref_last[k]) begin failures++; $display("FAIL rnd_raddr inst%0d c%0d: got %0d want %0d", k, c, raddr_o[k], ref_last[k]); end
        checks++;
        if (cnt_o[k] !== ref_cnt[k]) begin failures++; $display("FAIL rnd_cnt inst%0d c%0d: got %0d want %0d", k, c, cnt_o[k], ref_cnt[k]); end
      end
    end
    rst_ = 1'b1; idle_inputs();
  endtask

  task automatic test_wrap();
    logic [15:0] want [3];
    want[0] = 16'hFFFF; want[1] = 16'h0000; want[2] = 16'h0001;
    rst_ = 1'b0; idle_inputs();
    step();
    rst_ = 1'b1; req = 1'b1;
    for (int c = 0; c < 65534; c++) begin
      addr = DL'(c);
      step();
    end
    req = 1'b0;
    for (int c = 0; c < 4; c++) step();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (cnt_o[k] !== 16'hFFFE) begin failures++; $display("FAIL wrap_preset inst%0d: got %h want fffe", k, cnt_o[k]); end
    end
    for (int v = 0; v < 3; v++) begin
      req = 1'b1; addr = DL'($urandom);
      step();
      req = 1'b0;
      for (int c = 0; c < 4; c++) step();
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (cnt_o[k] !== want[v]) begin failures++; $display("FAIL wrap_cnt inst%0d step%0d: got %h want %h", k, v, cnt_o[k], want[v]); end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      for (int s = 0; s < 8; s++) sv[k][s] = 1'b0;
      ref_cnt[k] = '0;
      ref_last[k] = '0;
    end
    rst_ = 1'b0; idle_inputs(); addr = 0; ld_addr = 0; ld_data = 0;
    test_reset();
    load_mem();
    test_back_to_back();
    test_cancel();
    test_collision();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
